// File: rtl/seq_alu.sv
// Sequential ALU: registered result/NZCV, start/busy/done handshake,
// iterative MUL/DIV. Define SEQ_ALU_EARLY_TERM_EN for early-exit multiply.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             oe,
   output tri   [WIDTH-1:0] out,
   output logic [3:0]       status,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int M = WIDTH - 1;
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBB = 4'd3;
   localparam logic [3:0] OP_INC  = 4'd4;
   localparam logic [3:0] OP_DEC  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_NEG  = 4'd8;
   localparam logic [3:0] OP_PASA = 4'd9;
   localparam logic [3:0] OP_PASB = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_MULH = 4'd12;
   localparam logic [3:0] OP_DIVU = 4'd13;
   localparam logic [3:0] OP_REMU = 4'd14;

   typedef enum logic {IDLE, ITER} state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pend_q, pend_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               cin_q, cin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [3:0]         status_q, status_d;

   // Single-cycle datapath; subtraction runs as a + ~b + cin
   logic [WIDTH-1:0] opb;
   logic             cin0;
   logic             inv_c;
   logic [WIDTH:0]   asum;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             alu_v;

   always_comb begin
      opb   = '0;
      cin0  = 1'b0;
      inv_c = 1'b0;
      unique case (op_q)
         OP_ADD:  opb = b_q;
         OP_ADDC: begin
            opb  = b_q;
            cin0 = cin_q;
         end
         OP_SUB:  begin
            opb   = ~b_q;
            cin0  = 1'b1;
            inv_c = 1'b1;
         end
         OP_SUBB: begin
            opb   = ~b_q;
            cin0  = cin_q;
            inv_c = 1'b1;
         end
         OP_INC:  cin0 = 1'b1;
         OP_DEC:  begin
            opb   = '1;
            inv_c = 1'b1;
         end
         default: ;
      endcase
      asum = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, cin0};
   end

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      unique case (op_q)
         OP_ADD, OP_ADDC, OP_SUB,
         OP_SUBB, OP_INC, OP_DEC: begin
            alu_r = asum[WIDTH-1:0];
            alu_c = asum[WIDTH] ^ inv_c;
            alu_v = (a_q[M] == opb[M]) && (asum[M] != a_q[M]);
         end
         OP_SHL: begin
            alu_r = {a_q[WIDTH-2:0], 1'b0};
            alu_c = a_q[M];
         end
         OP_SHR: begin
            alu_r = {1'b0, a_q[WIDTH-1:1]};
            alu_c = a_q[0];
         end
         OP_NEG: begin
            alu_r = ~a_q + ONE;
            alu_v = (a_q == MSB_ONLY);
         end
         OP_PASA: alu_r = a_q;
         OP_PASB: alu_r = b_q;
         // only reached here on a zero divisor
         OP_DIVU: begin
            alu_r = '1;
            alu_v = 1'b1;
         end
         OP_REMU: begin
            alu_r = a_q;
            alu_v = 1'b1;
         end
         default: ;
      endcase
   end

   // Iteration step: shift-add multiply, restoring divide
   logic               is_div;
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] step_acc;
   logic [WIDTH-1:0]   step_res;
   logic [WIDTH-1:0]   mplier_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic               fin;
   logic               go;
   logic               multi;

   assign is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
   assign mul_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[M]};
   assign div_diff = div_sh - {1'b0, mcand_q[WIDTH-1:0]};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign step_acc = is_div
                   ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                   : mul_acc;
   assign step_res = (op_q == OP_MULH || op_q == OP_REMU)
                   ? step_acc[2*WIDTH-1:WIDTH]
                   : step_acc[WIDTH-1:0];
   assign mplier_nx = mplier_q >> 1;
   assign cnt_nx    = cnt_q - CNT_W'(1);

`ifdef SEQ_ALU_EARLY_TERM_EN
   assign fin = (cnt_nx == '0) || (!is_div && mplier_nx == '0);
`else
   assign fin = (cnt_nx == '0);
`endif

   assign go    = start && !busy_q;
   assign multi = (operation >= OP_MUL) && (operation <= OP_REMU)
               && !((operation >= OP_DIVU) && (b == '0));

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pend_d   = 1'b0;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      res_d    = res_q;
      status_d = status_q;

      if (pend_q) begin
         res_d    = alu_r;
         status_d = {alu_v, alu_r[M], ~|alu_r, alu_c};
         done_d   = 1'b1;
      end

      if (state_q == ITER) begin
         acc_d    = step_acc;
         mcand_d  = is_div ? mcand_q : (mcand_q << 1);
         mplier_d = mplier_nx;
         cnt_d    = cnt_nx;
         if (fin) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            res_d    = step_res;
            status_d = {1'b0, step_res[M], ~|step_res, 1'b0};
            done_d   = 1'b1;
         end
      end

      if (go) begin
         op_d  = operation;
         a_d   = a;
         b_d   = b;
         cin_d = carry_in;
         if (multi) begin
            state_d  = ITER;
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH);
            mplier_d = b;
            if (operation >= OP_DIVU) begin
               acc_d   = {{WIDTH{1'b0}}, a};
               mcand_d = {{WIDTH{1'b0}}, b};
            end else begin
               acc_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, a};
            end
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         res_q    <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pend_q   <= pend_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         res_q    <= res_d;
         status_q <= status_d;
      end
   end

   assign out    = oe ? res_q : {WIDTH{1'bz}};
   assign status = status_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: randomized ops checked against a
// plain-arithmetic reference model (honours SEQ_ALU_EARLY_TERM_EN).
module tb_seq_alu;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  operation;
   logic        carry_in;
   logic [31:0] a;
   logic [31:0] b;
   logic        oe;
   wire  [31:0] out;
   logic [3:0]  status;
   logic        busy;
   logic        done;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .operation(operation),
      .carry_in(carry_in),
      .a(a),
      .b(b),
      .oe(oe),
      .out(out),
      .status(status),
      .busy(busy),
      .done(done)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
      logic [3:0]  st;
      longint      due;
   } exp_t;

   exp_t   sbq[$];
   longint cyc = 0;
   int     n_vec = 0;
   int     n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic void model(
      input  logic [3:0]  op,
      input  logic [31:0] x,
      input  logic [31:0] y,
      input  logic        ci,
      output logic [31:0] r,
      output logic [3:0]  st,
      output int          lat,
      output logic        mc
   );
      longint sx;
      longint sy;
      longint t;
      logic [63:0] w;
      logic c;
      logic v;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      t = ci ? 0 : 1;
      c = 1'b0;
      v = 1'b0;
      lat = 1;
      mc = 1'b0;
      r = '0;
      case (op)
         4'd0: begin
            w = 64'(x) + 64'(y);
            r = w[31:0]; c = w[32]; v = ovf(sx + sy);
         end
         4'd1: begin
            w = 64'(x) + 64'(y) + 64'(ci);
            r = w[31:0]; c = w[32]; v = ovf(sx + sy + 64'(ci));
         end
         4'd2: begin
            r = x - y; c = x < y; v = ovf(sx - sy);
         end
         4'd3: begin
            r = x - y - 32'(t);
            c = 64'(x) < 64'(y) + 64'(t);
            v = ovf(sx - sy - t);
         end
         4'd4: begin
            r = x + 1; c = (x == 32'hFFFF_FFFF); v = ovf(sx + 1);
         end
         4'd5: begin
            r = x - 1; c = (x == 0); v = ovf(sx - 1);
         end
         4'd6: begin r = x << 1; c = x[31]; end
         4'd7: begin r = x >> 1; c = x[0]; end
         4'd8: begin r = 0 - x; v = ovf(-sx); end
         4'd9: r = x;
         4'd10: r = y;
         4'd11, 4'd12: begin
            w = 64'(x) * 64'(y);
            r = (op == 4'd11) ? w[31:0] : w[63:32];
            mc = 1'b1;
`ifdef SEQ_ALU_EARLY_TERM_EN
            lat = 1;
            for (int i = 0; i < 32; i++) if (y[i]) lat = i + 1;
`else
            lat = 32;
`endif
         end
         4'd13, 4'd14: begin
            if (y == 0) begin
               r = (op == 4'd13) ? 32'hFFFF_FFFF : x;
               v = 1'b1;
            end else begin
               r = (op == 4'd13) ? x / y : x % y;
               mc = 1'b1;
               lat = 32;
            end
         end
         default: r = '0;
      endcase
      st = {v, r[31], r == 0, c};
   endfunction

   task automatic issue(
      input logic [3:0]  op,
      input logic [31:0] x,
      input logic [31:0] y,
      input logic        ci
   );
      exp_t e;
      int   guard;
      int   lat;
      logic mc;
      guard = 0;
      while (busy) begin
         @(negedge clk);
         guard++;
         if (guard > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: busy=%b, required 0", busy);
            return;
         end
      end
      start = 1'b1;
      operation = op;
      a = x;
      b = y;
      carry_in = ci;
      model(op, x, y, ci, e.res, e.st, lat, mc);
      e.op = op;
      e.due = cyc + 1 + lat;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (busy !== mc) begin
         n_err++;
         $display("FAIL busy_after_start op%0d: busy=%b, required %b",
                  op, busy, mc);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sbq.size() != 0 || busy) begin
         @(negedge clk);
         guard++;
         if (guard > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: pending=%0d, required 0",
                     sbq.size());
            sbq.delete();
            return;
         end
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done === 1'b1) begin
         n_vec++;
         if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: out=%h, no operation pending",
                     out);
         end else begin
            e = sbq.pop_front();
            if (out !== e.res || status !== e.st || cyc != e.due) begin
               n_err++;
               $display("FAIL op%0d: out=%h st=%b cyc=%0d, required %h %b %0d",
                        e.op, out, status, cyc, e.res, e.st, e.due);
            end
         end
      end else if (rst_n && done !== 1'b0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_x: done=%b, required 0 or 1", done);
      end
   end

   function automatic logic [31:0] pick();
      logic [31:0] sp[5];
      sp[0] = 32'h0;
      sp[1] = 32'h1;
      sp[2] = 32'hFFFF_FFFF;
      sp[3] = 32'h8000_0000;
      sp[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300));
      return $urandom;
   endfunction

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      operation = '0;
      carry_in = 1'b0;
      a = '0;
      b = '0;
      oe = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (out !== 32'h0 || status !== 4'h0 || busy !== 1'b0
          || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: out=%h st=%b busy=%b done=%b, required 0",
                  out, status, busy, done);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);

      issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
      issue(4'd2, 32'h8000_0000, 32'h1, 1'b0);
      issue(4'd3, 32'd5, 32'd5, 1'b0);
      issue(4'd1, 32'h7FFF_FFFF, 32'h0, 1'b1);
      issue(4'd8, 32'h8000_0000, 32'h0, 1'b0);
      issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b0);
      issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b0);
      issue(4'd13, 32'd100, 32'd7, 1'b0);
      issue(4'd14, 32'd100, 32'd7, 1'b0);
      issue(4'd13, 32'd100, 32'd0, 1'b0);
      issue(4'd14, 32'd100, 32'd0, 1'b0);
      issue(4'd11, 32'd5, 32'd3, 1'b0);
      issue(4'd11, 32'd9, 32'd0, 1'b0);
      issue(4'd15, 32'd9, 32'd9, 1'b0);

      // start while busy must be ignored
      issue(4'd11, 32'h0001_2345, 32'h0000_6789, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      operation = 4'd0;
      a = 32'd1;
      b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      drain();

      for (int i = 0; i < 400; i++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick(),
               1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) @(negedge clk);
      end
      drain();
      repeat (2) @(negedge clk);

      oe = 1'b0;
      #1;
      n_vec++;
      if (out !== 32'hzzzz_zzzz) begin
         n_err++;
         $display("FAIL oe_low: out=%h, required zzzzzzzz", out);
      end
      oe = 1'b1;
      @(negedge clk);

      // reset in the middle of a divide
      issue(4'd13, 32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      sbq.delete();
      n_vec++;
      if (out !== 32'h0 || status !== 4'h0 || busy !== 1'b0
          || done !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: out=%h st=%b busy=%b done=%b, required 0",
                  out, status, busy, done);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);

      issue(4'd0, 32'd20, 32'd22, 1'b0);
      drain();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, clocked successor to the datapath ALU. Adds a start/busy/done handshake, registered result and NZCV status, and iterative unsigned multiply and divide. Sits between the data bus (a), the address bus (b) and the result bus (out). The control unit issues one operation at a time and stalls on busy.

Parameters:
WIDTH, 32, datapath width in bits (≥ 8).
CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  issue operation; sampled only when busy=0
operation  input  4  opcode, captured on accepted start
carry_in  input  1  carry for ADDC/SUBB, captured on start
a  input  WIDTH  operand A (data bus), captured on start
b  input  WIDTH  operand B (address bus), captured on start
oe  input  1  result-bus output enable
out  output(tri)  WIDTH  result register when oe=1, else high-Z
status  output  4  {V,N,Z,C}, registered
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse: result/status updated

Behaviour:
- Reset (async assert, sync release): state IDLE; result=0; status=0; busy=0; done=0; counter=0. Reset mid-operation aborts it; no done is issued.
- Opcodes: 0 ADD, 1 ADDC (a+b+cin), 2 SUB, 3 SUBB (a-b-~cin), 4 INC, 5 DEC, 6 SHL, 7 SHR, 8 NEG, 9 PASSA, 10 PASSB, 11 MUL (low word), 12 MULH (high word, unsigned), 13 DIVU (quotient), 14 REMU (remainder), 15 reserved (result 0).
- Arithmetic ops: C = bit WIDTH of the (WIDTH+1)-bit result. For SUB/SUBB/DEC, C=1 means borrow.
- V on ADD/ADDC/SUB/SUBB/INC/DEC: signed overflow.
- SHL: C=a[WIDTH-1]. SHR: C=a[0], logical shift.
- NEG: C=0; V=1 iff a = 1<<(WIDTH-1).
- PASS, MUL, reserved: C=0, V=0.
- N = result[WIDTH-1] and Z = (result==0) for every opcode. These are computed from the new result in the same update.
- Single-cycle ops (0–10, 15): start accepted at edge k → result, status and done=1 at edge k+1. busy stays 0.
- Multi-cycle ops (11–14), FSM IDLE→ITER→IDLE:
  - Edge k: capture operands, busy=1, counter=WIDTH.
  - Each ITER edge performs one shift-add (MUL) or restoring shift-subtract (DIV) step and decrements the counter.
  - The edge where the counter reaches 0 writes result and status, busy=0, done=1.
  - Latency: done at edge k+WIDTH; busy high WIDTH cycles.
- Divide by zero: no iteration. Done at k+1. DIVU gives all-ones with V=1; REMU gives a with V=1.
- start while busy=1: ignored; operands not captured.
- start in the cycle done is high: accepted, since busy=0.
- Result and status hold until the next done. out tracks oe combinationally.

Optional Feature:
SEQ_ALU_EARLY_TERM_EN
- Defined: MUL/MULH terminate once the remaining multiplier bits are all zero, with a minimum of 1 iteration. Latency is (index of highest set bit of b)+1 cycles. b=0 gives done at k+1 with result 0.
- Not defined: fixed WIDTH iterations.
- Results are identical either way.

Test Plan:
(All cases WIDTH=32.)
1. ADD a=0xFFFFFFFF, b=1 → done at k+1, out=0x00000000, status V0 N0 Z1 C1, busy never high.
2. SUB a=0x80000000, b=1 → out=0x7FFFFFFF, V1 N0 Z0 C0. SUBB a=5, b=5, cin=0 → out=0xFFFFFFFF, N1 C1.
3. MUL a=0x00010000, b=0x00010000 → busy high 32 cycles, done at k+32, out=0, Z1. MULH with the same operands → out=0x00000001.
4. DIVU a=100, b=7 → out=14 at k+32. REMU → out=2. DIVU b=0 → out=0xFFFFFFFF, V1, done at k+1. REMU b=0 → out=100, V1.
5. Protocol and reset:
   - MUL in flight, start with ADD at cycle 5 → ignored, MUL result unchanged.
   - oe=0 → out=Z.
   - rst_n low at cycle 10 of a DIVU → busy=0, out=0, status=0, no done pulse.
6. MUL a=5, b=3: with SEQ_ALU_EARLY_TERM_EN → done at k+2, out=15. Without → done at k+32, out=15.
